// File: rtl/sprite_pixel_reader.sv
// Sprite pixel reader: maps the scan position into sprite ROM coordinates,
// registers the returned palette index and gates it with the hit/blink/hidden
// visibility state. Fixed two-cycle latency from DrawX/DrawY to pix_*.
module sprite_pixel_reader #(
   parameter int unsigned SIZE         = 24,
   parameter int unsigned TRANSPARENT  = 0,
   parameter int unsigned BLINK_FRAMES = 60,
   parameter int unsigned BLINK_PERIOD = 8
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       draw_en,
   input  logic [9:0] PosX,
   input  logic [9:0] PosY,
   input  logic       frame_start,
   input  logic       hit,
   input  logic       respawn,
   output logic [5:0] DX,
   output logic [5:0] DY,
   input  logic [7:0] rom_data,
   output logic [7:0] pix_index,
   output logic       pix_opaque,
   output logic       blinking,
   output logic       hidden
);

   localparam int unsigned CntW = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned PerW = $clog2(BLINK_PERIOD + 1);

   localparam logic [10:0]     SizeL      = 11'(SIZE);
   localparam logic [7:0]      TranspL    = 8'(TRANSPARENT);
   localparam logic [CntW-1:0] LastFrame  = CntW'(BLINK_FRAMES - 1);
   localparam logic [PerW-1:0] LastPeriod = PerW'(BLINK_PERIOD - 1);

   typedef enum logic [1:0] {StVisible, StBlink, StHidden} state_e;

   state_e          state_q;
   logic [CntW-1:0] frame_cnt_q;
   logic [PerW-1:0] period_cnt_q;
   logic            phase_q;      // 1 = sprite shown during BLINK

   logic [10:0] rel_x;
   logic [10:0] rel_y;
   logic        in_x;
   logic        in_y;
   logic        in_box;
   logic        show;
   logic        in_box_d;
   logic        show_d;

   // Two's-complement offsets; bit 10 set means the scan is left of/above the sprite.
   assign rel_x = {1'b0, DrawX} - {1'b0, PosX};
   assign rel_y = {1'b0, DrawY} - {1'b0, PosY};
   assign in_x  = !rel_x[10] && (rel_x < SizeL);
   assign in_y  = !rel_y[10] && (rel_y < SizeL);
   assign in_box = draw_en && in_x && in_y;

   // Current visibility, sampled into the pipeline at stage 1.
   assign show = (state_q == StVisible) || ((state_q == StBlink) && phase_q);

   assign blinking = (state_q == StBlink);
   assign hidden   = (state_q == StHidden);

   // Stage 1: ROM address generation plus in-box/visibility side-band.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         DX       <= '0;
         DY       <= '0;
         in_box_d <= 1'b0;
         show_d   <= 1'b0;
      end else begin
         DX       <= in_box ? rel_x[5:0] : '0;
         DY       <= in_box ? rel_y[5:0] : '0;
         in_box_d <= in_box;
         show_d   <= show;
      end
   end

   // Stage 2: register the ROM palette index and the ownership flag.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_index  <= '0;
         pix_opaque <= 1'b0;
      end else begin
         pix_index  <= in_box_d ? rom_data : '0;
         pix_opaque <= in_box_d && show_d && (rom_data != TranspL);
      end
   end

   // Hit/blink/hidden FSM, counted in frames; respawn has priority over hit.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= StVisible;
         frame_cnt_q  <= '0;
         period_cnt_q <= '0;
         phase_q      <= 1'b1;
      end else begin
         case (state_q)
            StVisible: begin
               if (hit && !respawn) begin
                  state_q      <= StBlink;
                  frame_cnt_q  <= '0;
                  period_cnt_q <= '0;
                  phase_q      <= 1'b0;
               end
            end
            StBlink: begin
               if (respawn) begin
                  state_q      <= StVisible;
                  frame_cnt_q  <= '0;
                  period_cnt_q <= '0;
                  phase_q      <= 1'b1;
               end else if (frame_start) begin
                  frame_cnt_q <= frame_cnt_q + CntW'(1);
                  if (period_cnt_q == LastPeriod) begin
                     period_cnt_q <= '0;
                     phase_q      <= ~phase_q;
                  end else begin
                     period_cnt_q <= period_cnt_q + PerW'(1);
                  end
                  if (frame_cnt_q == LastFrame) begin
                     state_q <= StHidden;
                  end
               end
            end
            StHidden: begin
               if (respawn) begin
                  state_q      <= StVisible;
                  frame_cnt_q  <= '0;
                  period_cnt_q <= '0;
                  phase_q      <= 1'b1;
               end
            end
            default: begin
               state_q <= StVisible;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Directed bench for sprite_pixel_reader with a scoreboard for the pixel pipeline.
module tb_sprite_pixel_reader;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [9:0] DrawX, DrawY, PosX, PosY;
   logic       draw_en, frame_start, hit, respawn;
   logic [5:0] DX, DY;
   logic [7:0] rom_data;
   logic [7:0] pix_index;
   logic       pix_opaque, blinking, hidden;

   // ROM stand-in: either a constant or a coordinate-dependent pattern.
   logic       rom_sel;
   logic [7:0] rom_const;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   typedef struct {
      logic [5:0] dx;
      logic [5:0] dy;
      logic [7:0] idx;
      logic       opq;
   } exp_t;

   exp_t q[$];
   exp_t pend;
   bit   pend_v = 1'b0;

   always #5 Clk = ~Clk;

   sprite_pixel_reader dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .draw_en     (draw_en),
      .PosX        (PosX),
      .PosY        (PosY),
      .frame_start (frame_start),
      .hit         (hit),
      .respawn     (respawn),
      .DX          (DX),
      .DY          (DY),
      .rom_data    (rom_data),
      .pix_index   (pix_index),
      .pix_opaque  (pix_opaque),
      .blinking    (blinking),
      .hidden      (hidden)
   );

   function automatic logic [7:0] rom_f(int x, int y);
      if (((x + y) & 3) == 0) return 8'd0;
      return 8'(x * 9 + y);
   endfunction

   always_comb rom_data = rom_sel ? rom_f(int'(DX), int'(DY)) : rom_const;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One pixel per cycle: drive at negedge, record expectation, return just after the edge.
   task automatic cyc(int x, int y, bit en, bit show,
                      bit fs = 1'b0, bit h = 1'b0, bit rs = 1'b0);
      exp_t e;
      int rx, ry;
      bit inb;
      logic [7:0] v;
      @(negedge Clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      draw_en = en;
      frame_start = fs;
      hit = h;
      respawn = rs;
      rx = x - int'(PosX);
      ry = y - int'(PosY);
      inb = en && rx >= 0 && rx < 24 && ry >= 0 && ry < 24;
      v = rom_sel ? rom_f(inb ? rx : 0, inb ? ry : 0) : rom_const;
      e.dx = inb ? 6'(rx) : 6'd0;
      e.dy = inb ? 6'(ry) : 6'd0;
      e.idx = inb ? v : 8'd0;
      e.opq = inb && show && (v != 8'd0);
      q.push_back(e);
      @(posedge Clk);
      #1;
      frame_start = 1'b0;
      hit = 1'b0;
      respawn = 1'b0;
   endtask

   task automatic pulse(bit fs, bit h, bit rs);
      cyc(0, 0, 1'b0, 1'b0, fs, h, rs);
   endtask

   task automatic drain();
      draw_en = 1'b0;
      repeat (2) @(posedge Clk);
      #2;
   endtask

   // Scoreboard: address one cycle after drive, pixel two cycles after drive.
   always @(posedge Clk) begin
      #1;
      if (pend_v) begin
         check("pix_index", 32'(pix_index), 32'(pend.idx));
         check("pix_opaque", 32'(pix_opaque), 32'(pend.opq));
         pend_v = 1'b0;
      end
      if (q.size() > 0) begin
         pend = q.pop_front();
         check("DX", 32'(DX), 32'(pend.dx));
         check("DY", 32'(DY), 32'(pend.dy));
         pend_v = 1'b1;
      end
   end

   initial begin
      Reset_n = 1'b0;
      DrawX = '0; DrawY = '0; draw_en = 1'b0;
      PosX = 10'd100; PosY = 10'd50;
      frame_start = 1'b0; hit = 1'b0; respawn = 1'b0;
      rom_sel = 1'b0; rom_const = 8'd29;
      repeat (2) @(negedge Clk);
      check("rst_DX", 32'(DX), 32'd0);
      check("rst_DY", 32'(DY), 32'd0);
      check("rst_pix_index", 32'(pix_index), 32'd0);
      check("rst_pix_opaque", 32'(pix_opaque), 32'd0);
      check("rst_blinking", 32'(blinking), 32'd0);
      check("rst_hidden", 32'(hidden), 32'd0);
      Reset_n = 1'b1;

      // Interior pixel, then transparent pixel
      cyc(110, 60, 1'b1, 1'b1);
      drain();
      rom_const = 8'd0;
      cyc(110, 60, 1'b1, 1'b1);
      drain();

      // Box edges with a patterned ROM
      rom_sel = 1'b1;
      cyc(123, 60, 1'b1, 1'b1);
      cyc(124, 60, 1'b1, 1'b1);
      cyc(99, 60, 1'b1, 1'b1);
      cyc(100, 73, 1'b1, 1'b1);
      cyc(101, 74, 1'b1, 1'b1);
      cyc(105, 49, 1'b1, 1'b1);
      cyc(112, 62, 1'b1, 1'b1);
      cyc(110, 62, 1'b1, 1'b1);
      cyc(110, 61, 1'b0, 1'b1);
      cyc(5, 55, 1'b1, 1'b1);
      drain();

      // Blink sequence
      rom_sel = 1'b0;
      rom_const = 8'd1;
      pulse(1'b0, 1'b1, 1'b0);
      for (int f = 0; f < 60; f++) begin
         cyc(110, 60, 1'b1, ((f / 8) % 2) == 1);
         check("blink_active", 32'(blinking), 32'd1);
         pulse(1'b1, 1'b0, 1'b0);
      end
      check("hidden_after", 32'(hidden), 32'd1);
      check("blink_after", 32'(blinking), 32'd0);
      cyc(110, 60, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      check("respawn_hidden", 32'(hidden), 32'd0);
      cyc(110, 60, 1'b1, 1'b1);

      // Simultaneous hit/respawn, hit during blink, respawn during blink
      pulse(1'b0, 1'b1, 1'b1);
      check("hit_rs_same", 32'(blinking), 32'd0);
      cyc(110, 60, 1'b1, 1'b1);
      pulse(1'b0, 1'b1, 1'b0);
      repeat (5) pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      repeat (3) pulse(1'b1, 1'b0, 1'b0);
      cyc(110, 60, 1'b1, 1'b1);
      repeat (51) pulse(1'b1, 1'b0, 1'b0);
      check("frame59_blink", 32'(blinking), 32'd1);
      pulse(1'b1, 1'b0, 1'b0);
      check("frame60_hidden", 32'(hidden), 32'd1);
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b0, 1'b1, 1'b0);
      repeat (2) pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      check("rs_in_blink", 32'(blinking), 32'd0);
      cyc(110, 60, 1'b1, 1'b1);

      // Reset mid-blink with an in-box pixel in flight
      pulse(1'b0, 1'b1, 1'b0);
      repeat (3) pulse(1'b1, 1'b0, 1'b0);
      drain();
      DrawX = 10'd110; DrawY = 10'd60; draw_en = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("pre_rst_DX", 32'(DX), 32'd10);
      check("pre_rst_idx", 32'(pix_index), 32'd1);
      check("pre_rst_blink", 32'(blinking), 32'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_DX", 32'(DX), 32'd0);
      check("async_DY", 32'(DY), 32'd0);
      check("async_idx", 32'(pix_index), 32'd0);
      check("async_opq", 32'(pix_opaque), 32'd0);
      @(negedge Clk);
      draw_en = 1'b0;
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      check("post_rst_blink", 32'(blinking), 32'd0);
      check("post_rst_hidden", 32'(hidden), 32'd0);
      cyc(110, 60, 1'b1, 1'b1);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sprite_pixel_reader.md
Name: sprite_pixel_reader

Overview:
- Consumer side of the 24x24 sprite palette ROMs: converts the VGA scan position and a sprite's on-screen position into ROM row/column addresses (DY/DX), then registers the returned 8-bit palette index.
- Outputs a per-pixel palette index plus an opaque flag for the colour mapper.
- Holds a frame-counted hit/blink/hidden state machine, so the player sprite flashes after a collision and stays hidden until respawn.
- Sits between the VGA controller and the colour mapper; one instance per sprite.

Parameters:
- SIZE, 24: sprite width and height in pixels.
- TRANSPARENT, 0: palette index treated as transparent.
- BLINK_FRAMES, 60: frames spent in BLINK after a hit.
- BLINK_PERIOD, 8: frames per visibility toggle while in BLINK.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- draw_en  in  1  scan position is inside the active video area.
- PosX  in  10  sprite top-left column, sampled every cycle.
- PosY  in  10  sprite top-left row.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- hit  in  1  one-cycle collision pulse.
- respawn  in  1  one-cycle respawn pulse.
- DX  out  6  ROM column address.
- DY  out  6  ROM row address.
- rom_data  in  8  palette index returned by the ROM, valid in the same cycle as DX/DY.
- pix_index  out  8  registered palette index.
- pix_opaque  out  1  this sprite owns the pixel.
- blinking  out  1  FSM is in BLINK.
- hidden  out  1  FSM is in HIDDEN.

Behaviour:
- Reset (async assert, sync release):
  - DX, DY, pix_index = 0; pix_opaque = 0.
  - FSM = VISIBLE; frame counter = 0; blink phase = visible.
- Stage 1 (registered, cycle n+1):
  - relX = DrawX - PosX and relY = DrawY - PosY, computed 11-bit signed.
  - in_box = draw_en && 0 <= relX < SIZE && 0 <= relY < SIZE.
  - If in_box: DX = relX[5:0], DY = relY[5:0]; otherwise DX = DY = 0.
  - in_box_d and show_d (the current visibility) are registered alongside.
- Stage 2 (registered, cycle n+2):
  - pix_index = in_box_d ? rom_data : 0.
  - pix_opaque = in_box_d && show_d && rom_data != TRANSPARENT.
- Latency: fixed at 2 Clk from DrawX/DrawY to pix_*. There are no bubbles; one pixel is accepted per cycle.
- Sprite partially off-screen:
  - PosX > DrawX, i.e. negative rel → not in_box. No wrap-around in addresses.
  - Right edge: relX = SIZE-1 is in; relX = SIZE is out.
- FSM states: VISIBLE, BLINK, HIDDEN.
  - VISIBLE → BLINK on hit. Clear frame counter; blink phase = hidden.
  - BLINK: on each frame_start, frame counter +1. Toggle blink phase every BLINK_PERIOD frames. When counter reaches BLINK_FRAMES → HIDDEN.
  - HIDDEN → VISIBLE on respawn.
  - hit while in BLINK or HIDDEN: ignored.
  - respawn while in BLINK: → VISIBLE immediately; counter cleared.
  - hit and respawn in the same cycle: respawn wins, result is VISIBLE.
  - Visibility (show):
    - VISIBLE: 1.
    - BLINK: blink phase.
    - HIDDEN: 0.
- Visibility is applied only through show_d in the pipeline. A state change mid-line affects pixels whose stage 1 occurs on or after the change.
- blinking and hidden are decoded directly from the state register.
- Reset asserted mid-frame forces all outputs to their reset values immediately; the pipeline refills within 2 cycles after release.

Test Plan:
1. Interior pixel: PosX=100, PosY=50, DrawX=110, DrawY=60, draw_en=1.
   - Next cycle: DX=10, DY=10.
   - With rom_data=29, two cycles after the input: pix_index=29, pix_opaque=1.
2. Transparent pixel: same position, rom_data=0 → pix_index=0, pix_opaque=0.
3. Box edges: PosX=100, PosY=50.
   - DrawX=123 → DX=23, in box.
   - DrawX=124 → DX=0, pix_opaque=0.
   - DrawX=99 → out of box.
   - draw_en=0 → out of box regardless of position.
4. Blink sequence: hit pulse, then 60 frame_start pulses with rom_data=1 on in-box pixels.
   - blinking=1 throughout the 60 frames.
   - pix_opaque alternates every 8 frames, starting at 0.
   - After the 60th frame: hidden=1, pix_opaque=0.
   - respawn → hidden=0, pix_opaque returns to 1.
5. Simultaneous hit and respawn in VISIBLE → stays VISIBLE. A hit during BLINK does not restart the frame counter.
6. Reset_n low mid-BLINK with an in-box pixel → pix_index=0, pix_opaque=0, DX=DY=0 asynchronously. After release: state VISIBLE, blinking=0.
